// File: rtl/ra_pq_param_pkg.sv
// Shared types and width helpers for the parametrised register-array priority queue.
// The fixed-size kv_t is kept for the legacy wrappers that still use it.
package ra_pq_param_pkg;

    typedef struct packed {
        logic [7:0] key;
        logic [7:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        PQ_IDLE,
        PQ_ENQ,
        PQ_DEQ,
        PQ_REPL
    } pq_op_t;

    function automatic int pq_kw(input int key_w, input int val_w);
        return key_w + val_w;
    endfunction

    // Width able to hold 0..depth inclusive.
    function automatic int pq_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ra_pq_param_ins_pos.sv
// Insert-position encoder: first valid slot whose key the new key strictly beats,
// else the count. Strictness makes equal keys queue behind existing equals.
module ra_pq_param_ins_pos #(
    parameter int KEY_W     = 8,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1,
    parameter int CW        = 4
) (
    input  logic [DEPTH-1:0][KEY_W-1:0] keys,
    input  logic [CW-1:0]               cnt,
    input  logic [KEY_W-1:0]            new_key,
    output logic [CW-1:0]               pos
);

    always_comb begin
        pos = cnt;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < cnt) begin
                if ((MIN_FIRST != 0) ? (new_key < keys[i]) : (new_key > keys[i]))
                    pos = CW'(i);
            end
        end
    end

endmodule

// File: rtl/ra_pq_param.sv
// Sorted register-array priority queue with stable ties, single-cycle replace,
// occupancy count and registered overflow/underflow pulses.
module ra_pq_param
    import ra_pq_param_pkg::*;
#(
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1,
    localparam int KVW      = pq_kw(KEY_W, VAL_W),
    localparam int CW       = pq_cw(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [KVW-1:0] kvi,
    input  logic           enq,
    input  logic           deq,
    output logic [KVW-1:0] kvo,
    output logic           full,
    output logic           empty,
    output logic           busy,
    output logic [CW-1:0]  count,
    output logic           ovf,
    output logic           unf
);

    logic [DEPTH-1:0][KVW-1:0]   ent_q, ent_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        ovf_q, ovf_d;
    logic                        unf_q, unf_d;

    pq_op_t                      op;
    logic [DEPTH-1:0][KVW-1:0]   base;
    logic [DEPTH-1:0][KVW-1:0]   base_sh;
    logic [DEPTH-1:0][KEY_W-1:0] base_keys;
    logic [CW-1:0]               base_cnt;
    logic [CW-1:0]               ins_pos;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Base view: the array as it stands, or with the head already popped for deq/replace.
    always_comb begin
        op = PQ_IDLE;
        if (enq && deq && !empty)
            op = PQ_REPL;
        else if (enq && !full)
            op = PQ_ENQ;
        else if (deq && !enq && !empty)
            op = PQ_DEQ;

        base     = ent_q;
        base_cnt = count_q;
        if (op == PQ_DEQ || op == PQ_REPL) begin
            for (int i = 0; i < DEPTH - 1; i++)
                base[i] = ent_q[i+1];
            base[DEPTH-1] = '0;
            base_cnt      = count_q - CW'(1);
        end

        base_sh[0] = '0;
        for (int i = 1; i < DEPTH; i++)
            base_sh[i] = base[i-1];

        for (int i = 0; i < DEPTH; i++)
            base_keys[i] = base[i][KVW-1 -: KEY_W];
    end

    ra_pq_param_ins_pos #(
        .KEY_W     (KEY_W),
        .DEPTH     (DEPTH),
        .MIN_FIRST (MIN_FIRST),
        .CW        (CW)
    ) u_ins_pos (
        .keys    (base_keys),
        .cnt     (base_cnt),
        .new_key (kvi[KVW-1 -: KEY_W]),
        .pos     (ins_pos)
    );

    always_comb begin
        ent_d   = base;
        count_d = count_q;
        ovf_d   = enq && !deq && full;
        unf_d   = deq && empty;

        if (op == PQ_ENQ || op == PQ_REPL) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < ins_pos)
                    ent_d[i] = base[i];
                else if (CW'(i) == ins_pos)
                    ent_d[i] = kvi;
                else
                    ent_d[i] = base_sh[i];
            end
        end

        case (op)
            PQ_ENQ:  count_d = count_q + CW'(1);
            PQ_DEQ:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign kvo   = ent_q[0];
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign busy  = 1'b0;

endmodule

// File: doc/ra_pq_param.md
Name: ra_pq_param

Overview:
- Parametrised register-array priority queue; next generation of the fixed-size kv_t register-array PQ.
- Generalised in key width, value width, depth and ordering (min-first or max-first).
- Adds FIFO-stable tie-break, single-cycle replace (enq+deq together), occupancy count and overflow/underflow pulses.
- Sits behind the existing PQ interface wrappers as the reusable core for synthesis sweeps.

Parameters:
- KEY_W, 8, key width in bits.
- VAL_W, 8, value width in bits.
- DEPTH, 8, number of entries; must be ≥2.
- MIN_FIRST, 1, 1 = smallest key at head; 0 = largest key at head.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- kvi  in  KEY_W+VAL_W  entry to enqueue; key in MSBs, value in LSBs.
- enq  in  1  enqueue request, sampled on rising clk.
- deq  in  1  dequeue request, sampled on rising clk.
- kvo  out  KEY_W+VAL_W  current head entry; valid only when empty=0.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  constant 0; kept for interface compatibility.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- ovf  out  1  one-cycle pulse: enq dropped because queue full.
- unf  out  1  one-cycle pulse: deq ignored because queue empty.

Behaviour:
- Storage: array ent[0..DEPTH-1] kept sorted; ent[0] is head. Entries at index ≥ count are don't-care, but are driven to 0 on reset.
- "Better" relation: key strictly less (MIN_FIRST=1) or strictly greater (MIN_FIRST=0). Unsigned compare.
- Reset (rst=1): count=0, all ent=0, ovf=0, unf=0. Outputs: kvo=0, empty=1, full=0, busy=0. Reset wins over any same-cycle enq/deq.
- kvo = ent[0], combinational from registers. Insert/remove is visible on kvo the cycle after the request edge.
- Operation is selected per cycle from {enq, deq, empty, full}:
  - idle (enq=0, deq=0): no change.
  - enq only, not full: insert position p = first i < count with kvi.key better than ent[i].key, else p = count. ent[p+1..count] ← ent[p..count-1]; ent[p] ← kvi; count+1. Equal keys therefore stay FIFO: new entry lands behind existing equals.
  - enq only, full: no change; ovf=1 for one cycle.
  - deq only, not empty: ent[i] ← ent[i+1] for i < count-1; count-1.
  - deq only, empty: no change; unf=1.
  - enq+deq, not empty (replace): remove head, then insert kvi into the remaining entries with the same rule. Count unchanged. Legal when full; ovf=0.
  - enq+deq, empty: enq proceeds as enq-only; deq ignored; unf=1. No bypass of kvi to kvo in the same cycle.
- ovf and unf are registered pulses, high exactly the cycle after the offending edge.
- Latency: one clock for every operation; a new request is accepted every cycle.
- Mid-operation reset: rst overrides; the queue is empty the next cycle.

Decomposition:
- pq_pkg additions:
  - function pq_kw(KEY_W, VAL_W) returning the packed width.
  - pq_op_t enum {PQ_IDLE, PQ_ENQ, PQ_DEQ, PQ_REPL}.
  - localparam-style helper for the count width.
- The existing fixed kv_t stays untouched.
- One natural sub-module, pq_ins_pos: combinational priority encoder taking keys, count and new key, returning insert index p. Used with a shifted view of the array for replace.
- Top-level holds the array, count register, op decode and pulse flags.

Test Plan (KEY_W=8, VAL_W=8, DEPTH=4, MIN_FIRST=1; entries written key:val):
- Reset then idle: rst for 2 cycles -> empty=1, full=0, count=0, kvo=0, ovf=unf=0, busy=0.
- Sort/stable: enq 30:01, 10:02, 30:03, 20:04 on consecutive cycles -> full=1, count=4. Then deq ×4 yields kvo 10:02, 20:04, 30:01, 30:03, then empty=1.
- Overflow/replace when full: fill with 10,20,30,40; enq 05 alone -> ovf pulse, contents unchanged. enq 25 with deq -> count stays 4, head sequence 20,25,30,40.
- Underflow: deq on empty -> unf=1 for one cycle, count=0. enq 07+deq on empty -> unf=1, count=1, kvo=07.
- Max mode (MIN_FIRST=0): enq 10, 40, 20 -> deq order 40, 20, 10.
- Reset mid-stream: rst together with enq+deq at count=3 -> next cycle count=0, empty=1, no ovf/unf.
